dcache_controller: RTL and testbench

//  Direct-mapped, write-back, write-allocate data cache between CPU load/store path and 256x8 data memory.
//  CPU side: read/write/address/writedata/readdata/busywait; hits complete without stalling.

---
 rtl/dcache_controller.sv | 212 +++++++++++++++++++++
 tb/tb_dcache_controller.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_controller.sv
// Direct-mapped write-back/write-allocate data cache; refills and evicts 4-byte blocks as byte beats.
// Ports: clock/reset, cpu_* load/store side, mem_* byte memory initiator, hit_count/miss_count (DCACHE_STATS_EN).
module dcache_controller #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int INDEX_W  = 3,
  parameter int OFFSET_W = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [DATA_W-1:0] cpu_writedata,
  output logic [DATA_W-1:0] cpu_readdata,
  output logic              cpu_busywait,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,
  input  logic              mem_busywait,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count
);

  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
  localparam int NBLK  = 1 << INDEX_W;
  localparam int NBYTE = 1 << OFFSET_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WBACK,
    S_FETCH,
    S_UPDATE
  } state_e;

  state_e state_q, state_d;

  logic [TAG_W-1:0]    tag_w;
  logic [INDEX_W-1:0]  idx_w;
  logic [OFFSET_W-1:0] off_w;
  assign {tag_w, idx_w, off_w} = cpu_address;

  logic              valid_q [NBLK];
  logic              dirty_q [NBLK];
  logic [TAG_W-1:0]  tag_q   [NBLK];
  logic [DATA_W-1:0] data_q  [NBLK][NBYTE];

  logic [OFFSET_W-1:0] beat_q, beat_d;
  logic                mrd_q, mrd_d;
  logic                mwr_q, mwr_d;
  logic [ADDR_W-1:0]   maddr_q, maddr_d;
  logic [DATA_W-1:0]   mwdata_q, mwdata_d;

  logic rd_req, wr_req, acc, hit;
  logic wr_hit, fill_we, upd;

  assign rd_req = cpu_read & ~cpu_write;
  assign wr_req = cpu_write & ~cpu_read;
  assign acc    = rd_req | wr_req;
  assign hit    = valid_q[idx_w] && (tag_q[idx_w] == tag_w);

  assign cpu_busywait = (acc && !hit) || (state_q != S_IDLE);
  assign cpu_readdata = (rd_req && hit) ? data_q[idx_w][off_w] : '0;

  assign mem_read      = mrd_q;
  assign mem_write     = mwr_q;
  assign mem_address   = maddr_q;
  assign mem_writedata = mwdata_q;

  logic [ADDR_W-1:0] wb_addr, fe_addr;
  assign wb_addr = {tag_q[idx_w], idx_w, beat_q};
  assign fe_addr = {tag_w, idx_w, beat_q};

  // A beat completes on an edge with the request high and memory not busy;
  // the request then drops for one gap cycle before the next beat is issued.
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    mrd_d    = 1'b0;
    mwr_d    = 1'b0;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    wr_hit   = 1'b0;
    fill_we  = 1'b0;
    upd      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (acc && hit) begin
          wr_hit = wr_req;
        end else if (acc) begin
          if (valid_q[idx_w] && dirty_q[idx_w]) begin
            state_d  = S_WBACK;
            mwr_d    = 1'b1;
            maddr_d  = wb_addr;
            mwdata_d = data_q[idx_w][beat_q];
          end else begin
            state_d = S_FETCH;
            mrd_d   = 1'b1;
            maddr_d = fe_addr;
          end
        end
      end
      S_WBACK: begin
        if (mwr_q) begin
          if (!mem_busywait) begin
            beat_d = beat_q + 1'b1;
            if (beat_q == '1) state_d = S_FETCH;
          end else begin
            mwr_d = 1'b1;
          end
        end else begin
          mwr_d    = 1'b1;
          maddr_d  = wb_addr;
          mwdata_d = data_q[idx_w][beat_q];
        end
      end
      S_FETCH: begin
        if (mrd_q) begin
          if (!mem_busywait) begin
            fill_we = 1'b1;
            beat_d  = beat_q + 1'b1;
            if (beat_q == '1) state_d = S_UPDATE;
          end else begin
            mrd_d = 1'b1;
          end
        end else begin
          mrd_d   = 1'b1;
          maddr_d = fe_addr;
        end
      end
      S_UPDATE: begin
        upd     = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      beat_q   <= '0;
      mrd_q    <= 1'b0;
      mwr_q    <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= '0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      mrd_q    <= mrd_d;
      mwr_q    <= mwr_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NBLK; i++) begin
        valid_q[i] <= 1'b0;
        dirty_q[i] <= 1'b0;
      end
    end else begin
      if (wr_hit) dirty_q[idx_w] <= 1'b1;
      if (upd) begin
        valid_q[idx_w] <= 1'b1;
        dirty_q[idx_w] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (wr_hit) data_q[idx_w][off_w] <= cpu_writedata;
    if (fill_we) data_q[idx_w][beat_q] <= mem_readdata;
    if (upd) tag_q[idx_w] <= tag_w;
  end

`ifdef DCACHE_STATS_EN
  // replay_q marks the post-refill retry so it is counted as the miss it was.
  logic        replay_q;
  logic [15:0] hit_q, miss_q;
  logic        done;
  assign done = (state_q == S_IDLE) && acc && hit;

  always_ff @(posedge clock) begin
    if (reset) begin
      replay_q <= 1'b0;
      hit_q    <= '0;
      miss_q   <= '0;
    end else begin
      if (upd) replay_q <= 1'b1;
      else if (done) replay_q <= 1'b0;
      if (done) begin
        if (replay_q) begin
          if (miss_q != 16'hFFFF) miss_q <= miss_q + 16'd1;
        end else begin
          if (hit_q != 16'hFFFF) hit_q <= hit_q + 16'd1;
        end
      end
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller with a 256x8 byte memory responder and a cache model.
// Ports driven: all dcache_controller ports.
module tb_dcache_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       cpu_read, cpu_write;
  logic [7:0] cpu_address, cpu_writedata, cpu_readdata;
  logic       cpu_busywait;
  logic       mem_read, mem_write;
  logic [7:0] mem_address, mem_writedata;
  logic [7:0] mem_readdata = 8'h00;
  logic       mem_busywait;
  logic [15:0] hit_count, miss_count;

  always #50 clk = ~clk;

  dcache_controller dut (
    .clock(clk), .reset(reset),
    .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_address(cpu_address), .cpu_writedata(cpu_writedata),
    .cpu_readdata(cpu_readdata), .cpu_busywait(cpu_busywait),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_writedata(mem_writedata),
    .mem_readdata(mem_readdata), .mem_busywait(mem_busywait),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  // Byte memory: busy from request rise until 40 units after the next edge.
  logic [7:0] mem_arr [256];
  logic served = 1'b0;
  assign mem_busywait = (mem_read | mem_write) & ~served;

  always @(posedge clk) begin
    if ((mem_read || mem_write) && !served) begin
      #40;
      if (mem_read) mem_readdata = mem_arr[mem_address];
      else mem_arr[mem_address] = mem_writedata;
      served = 1'b1;
    end else if (!(mem_read || mem_write)) begin
      served = 1'b0;
    end
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Cache model
  typedef struct {
    bit         w;
    logic [7:0] a;
    logic [7:0] d;
  } beat_t;

  beat_t      expq[$];
  bit         mv  [8];
  bit         mdy [8];
  logic [2:0] mt  [8];
  logic [7:0] md  [8][4];
  logic [7:0] smem[256];
  logic [7:0] exp_rdata;
  int         nhit, nmiss;
  int         nrd, nwr;
  logic [7:0] last_rd;

  // Compare process
  logic prev_rd = 1'b0, prev_wr = 1'b0;
  always @(negedge clk) begin
    if (mem_read && mem_write) chk("rd_wr_both", 1, 0);
    if ((mem_read && !prev_rd) || (mem_write && !prev_wr)) begin
      if (mem_read) nrd++;
      else nwr++;
      if (expq.size() == 0) begin
        chk("unexpected_beat", {24'h0, mem_address}, 32'hFFFF);
      end else begin
        beat_t b;
        b = expq.pop_front();
        chk("beat_kind", {31'h0, mem_write}, {31'h0, b.w});
        chk("beat_addr", {24'h0, mem_address}, {24'h0, b.a});
        if (b.w) chk("beat_wdata", {24'h0, mem_writedata}, {24'h0, b.d});
      end
    end
    if (cpu_read && !cpu_write && !cpu_busywait) begin
      chk("readdata", {24'h0, cpu_readdata}, {24'h0, exp_rdata});
      last_rd = cpu_readdata;
    end
    prev_rd = mem_read;
    prev_wr = mem_write;
  end

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      mv[i]  = 1'b0;
      mdy[i] = 1'b0;
    end
    nhit  = 0;
    nmiss = 0;
    expq.delete();
  endtask

  task automatic do_access(input bit rd, input bit wr, input logic [7:0] addr, input logic [7:0] wd);
    logic [2:0] idx, tg;
    logic [1:0] off;
    bit         h;
    int         stalls;
    idx = addr[4:2];
    tg  = addr[7:5];
    off = addr[1:0];
    h   = mv[idx] && (mt[idx] == tg);
    if (!h) begin
      if (mv[idx] && mdy[idx]) begin
        for (int b = 0; b < 4; b++) begin
          logic [7:0] a;
          a = {mt[idx], idx, 2'(b)};
          expq.push_back('{1'b1, a, md[idx][b]});
          smem[a] = md[idx][b];
        end
      end
      for (int b = 0; b < 4; b++) begin
        logic [7:0] a;
        a = {tg, idx, 2'(b)};
        expq.push_back('{1'b0, a, smem[a]});
        md[idx][b] = smem[a];
      end
      mv[idx]  = 1'b1;
      mt[idx]  = tg;
      mdy[idx] = 1'b0;
      nmiss++;
    end else begin
      nhit++;
    end
    if (wr) begin
      md[idx][off] = wd;
      mdy[idx]     = 1'b1;
    end
    exp_rdata     = md[idx][off];
    cpu_address   = addr;
    cpu_writedata = wd;
    cpu_read      = rd;
    cpu_write     = wr;
    stalls = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (!cpu_busywait) break;
      stalls++;
    end
    if (stalls >= 200) chk("access_timeout", stalls, 0);
    chk("stall_vs_hit", {31'h0, stalls == 0}, {31'h0, h});
    @(posedge clk);
    #1;
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
    chk("beats_drained", expq.size(), 0);
  endtask

  int rd0, wr0;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_arr[i] = 8'h00;
      smem[i]    = 8'h00;
    end
    model_reset();
    reset = 1'b1;
    cpu_read = 1'b0;
    cpu_write = 1'b0;
    cpu_address = 8'h00;
    cpu_writedata = 8'h00;
    exp_rdata = 8'h00;
    nrd = 0;
    nwr = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", {31'h0, cpu_busywait}, 0);
    chk("rst_mrd", {31'h0, mem_read}, 0);
    chk("rst_mwr", {31'h0, mem_write}, 0);
    chk("rst_maddr", {24'h0, mem_address}, 0);
    chk("rst_hits", {16'h0, hit_count}, 0);
    @(posedge clk);
    #1;

    // 1: clean miss
    rd0 = nrd; wr0 = nwr;
    do_access(1, 0, 8'h00, 8'h00);
    chk("t1_reads", nrd - rd0, 4);
    chk("t1_writes", nwr - wr0, 0);
    chk("t1_rdata", {24'h0, last_rd}, 32'h00);

    // 2: write hit then read hit
    do_access(0, 1, 8'h01, 8'h05);
    do_access(1, 0, 8'h01, 8'h00);
    chk("t2_rdata", {24'h0, last_rd}, 32'h05);

    // 3: dirty eviction
    rd0 = nrd; wr0 = nwr;
    do_access(1, 0, 8'h21, 8'h00);
    chk("t3_writes", nwr - wr0, 4);
    chk("t3_reads", nrd - rd0, 4);
    chk("t3_mem01", {24'h0, mem_arr[8'h01]}, 32'h05);

    // 4: clean refetch
    wr0 = nwr;
    do_access(1, 0, 8'h01, 8'h00);
    chk("t4_writes", nwr - wr0, 0);
    chk("t4_rdata", {24'h0, last_rd}, 32'h05);
`ifdef DCACHE_STATS_EN
    chk("t4_hits", {16'h0, hit_count}, 2);
    chk("t4_miss", {16'h0, miss_count}, 3);
`else
    chk("t4_hits", {16'h0, hit_count}, 0);
    chk("t4_miss", {16'h0, miss_count}, 0);
`endif

    // 5: reset during fetch beat 2
    cpu_address = 8'h21;
    cpu_read    = 1'b1;
    for (int b = 0; b < 4; b++)
      expq.push_back('{1'b0, {3'd1, 3'd0, 2'(b)}, 8'h00});
    begin
      int n;
      for (n = 0; n < 200; n++) begin
        @(negedge clk);
        if (mem_read && mem_address == 8'h22) break;
      end
      if (n >= 200) chk("t5_timeout", n, 0);
    end
    reset    = 1'b1;
    cpu_read = 1'b0;
    @(posedge clk);
    #1;
    chk("t5_mrd", {31'h0, mem_read}, 0);
    chk("t5_busy", {31'h0, cpu_busywait}, 0);
    reset = 1'b0;
    model_reset();
    do_access(1, 0, 8'h21, 8'h00);

    // eviction carrying a nonzero byte through memory
    do_access(0, 1, 8'h23, 8'h3C);
    do_access(1, 0, 8'h43, 8'h00);
    chk("mem23", {24'h0, mem_arr[8'h23]}, 32'h3C);
    do_access(1, 0, 8'h23, 8'h00);
    chk("rd23", {24'h0, last_rd}, 32'h3C);
    do_access(0, 1, 8'h17, 8'h9A);
    do_access(1, 0, 8'h17, 8'h00);
    chk("rd17", {24'h0, last_rd}, 32'h9A);

    // 6: illegal read+write
    rd0 = nrd; wr0 = nwr;
    cpu_address   = 8'h04;
    cpu_writedata = 8'hEE;
    cpu_read      = 1'b1;
    cpu_write     = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t6_busy", {31'h0, cpu_busywait}, 0);
    end
    @(posedge clk);
    #1;
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
    repeat (2) @(negedge clk);
    chk("t6_traffic", (nrd - rd0) + (nwr - wr0), 0);

`ifdef DCACHE_STATS_EN
    chk("end_hits", {16'h0, hit_count}, nhit);
    chk("end_miss", {16'h0, miss_count}, nmiss);
`else
    chk("end_hits", {16'h0, hit_count}, 0);
    chk("end_miss", {16'h0, miss_count}, 0);
`endif
    chk("end_queue", expq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
